// File: rtl/softmax_max_sub.sv
// Loads one vector of FP16 scores while tracking the running max, then streams
// x_i - max (always <= 0) to the exponential stage through a registered output.
module softmax_max_sub #(
  parameter int VEC_LEN = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy
);
  localparam int CNT_W = $clog2(VEC_LEN) + 1;
  localparam int IDX_W = $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(VEC_LEN);

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic [15:0]      max_q;
  logic [15:0]      vbuf [VEC_LEN];
  logic [15:0]      rd_data, sub_res;
  logic             accept, out_load, last_hs;

  // Monotonic unsigned key for FP16 ordering; +0 ranks above -0.
  function automatic logic [15:0] key(input logic [15:0] x);
    return x[15] ? ~x : {1'b1, x[14:0]};
  endfunction

  // FP16 x - y, round to nearest even; any zero result is +0.
  function automatic logic [15:0] fp_sub(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] yn, a, b, r;
    logic [4:0]  ea, eb, d, cap, shl;
    logic [10:0] ma, mb;
    logic [42:0] sh;
    logic [13:0] ax, bx, n;
    logic [14:0] s, pk;
    logic [5:0]  e;
    logic [3:0]  lz;
    logic        rup;
    yn = {~y[15], y[14:0]};
    if (x[14:0] >= yn[14:0]) begin a = x; b = yn; end
    else begin a = yn; b = x; end
    ea = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    eb = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    ma = {|a[14:10], a[9:0]};
    mb = {|b[14:10], b[9:0]};
    d  = ea - eb;
    // Align the smaller operand keeping guard, round and a sticky bit.
    sh = {mb, 32'd0} >> d;
    bx = {sh[42:30], |sh[29:0]};
    ax = {ma, 3'b000};
    s  = (a[15] ^ b[15]) ? ({1'b0, ax} - {1'b0, bx}) : ({1'b0, ax} + {1'b0, bx});
    lz = 4'd0;
    for (int i = 0; i < 14; i++) if (s[i]) lz = 4'(13 - i);
    n   = s[13:0];
    e   = {1'b0, ea};
    cap = ea - 5'd1;
    shl = 5'd0;
    if (s[14]) begin
      n = {s[14:2], s[1] | s[0]};
      e = {1'b0, ea} + 6'd1;
    end else begin
      // Normalise no further than the subnormal exponent.
      shl = ({1'b0, lz} < cap) ? {1'b0, lz} : cap;
      n   = s[13:0] << shl;
      e   = {1'b0, ea} - {1'b0, shl};
    end
    rup = n[2] & (n[1] | n[0] | n[3]);
    // Exponent/fraction added as one field so rounding carries propagate to Inf.
    pk  = {(n[13] ? e[4:0] : 5'd0), n[12:3]} + {14'd0, rup};
    if (s == 15'd0)       r = 16'h0000;
    else if (e >= 6'd31)  r = {a[15], 15'h7C00};
    else                  r = {a[15], pk};
    return r;
  endfunction

  assign accept   = in_valid && in_ready;
  assign last_hs  = out_valid && out_ready && out_last;
  assign out_load = (state_q == DRAIN) && (rd_cnt < FULL) && (!out_valid || out_ready);
  assign rd_data  = vbuf[IDX_W'(rd_cnt)];
  assign sub_res  = fp_sub(rd_data, max_q);

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= LOAD;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && wr_cnt == LAST) state_d = DRAIN;
      DRAIN:   if (last_hs)                  state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready = (state_q == LOAD);
    busy     = (state_q == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (accept) vbuf[IDX_W'(wr_cnt)] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      max_q     <= 16'h0000;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + 1'b1;
        if (wr_cnt == '0 || key(in_data) > key(max_q)) max_q <= in_data;
        if (wr_cnt == LAST) rd_cnt <= '0;
      end
      if (last_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (out_load) begin
        out_data  <= sub_res;
        out_valid <= 1'b1;
        out_last  <= (rd_cnt == LAST);
        rd_cnt    <= rd_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_softmax_max_sub.sv
// Directed and random checks of softmax_max_sub against a real-arithmetic reference.
module tb_softmax_max_sub;
  localparam int VL = 4;

  logic        clk, resetn, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [15:0] in_data, out_data;
  int          checks = 0, failures = 0;
  logic [16:0] exp_q [$];
  bit          rdy_rand = 0;
  bit          hold_pending = 0;
  logic [15:0] hold_data;
  logic        hold_last;

  softmax_max_sub #(.VEC_LEN(VL)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic real pow2(input int e);
    real p = 1.0;
    if (e >= 0) repeat (e) p = p * 2.0;
    else        repeat (-e) p = p / 2.0;
    return p;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    int  f = int'(h[9:0]);
    real m;
    if (e == 0) m = real'(f) * pow2(-24);
    else        m = real'(f + 1024) * pow2(e - 25);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    logic s = (v < 0.0);
    real  a = s ? -v : v;
    real  m, fl;
    int   e, q;
    bit   sub;
    if (a == 0.0) return 16'h0000;
    if (a >= 65520.0) return {s, 15'h7C00};
    sub = (a < pow2(-14));
    e = -14;
    if (sub) m = a * pow2(24);
    else begin
      while (a >= pow2(e + 1)) e++;
      m = a * pow2(10 - e);
    end
    fl = $floor(m);
    q  = int'(fl);
    if ((m - fl) > 0.5 || ((m - fl) == 0.5 && (q % 2) == 1)) q++;
    if (sub) return {s, 15'(q)};
    if (q == 2048) begin q = 1024; e++; end
    if (e > 15) return {s, 15'h7C00};
    return {s, 5'(e + 15), 10'(q - 1024)};
  endfunction

  task automatic push_exp(input logic [VL-1:0][15:0] v);
    real mx = h2r(v[0]);
    for (int i = 1; i < VL; i++) if (h2r(v[i]) > mx) mx = h2r(v[i]);
    for (int i = 0; i < VL; i++) exp_q.push_back({(i == VL - 1), r2h(h2r(v[i]) - mx)});
  endtask

  task automatic send_vec(input logic [VL-1:0][15:0] v, input int gap, output int wait0);
    bit acc;
    int t;
    push_exp(v);
    wait0 = 0;
    for (int i = 0; i < VL; i++) begin
      in_valid = 0;
      while ($urandom_range(99) < gap) begin @(posedge clk); #1; end
      in_valid = 1;
      in_data  = v[i];
      t = 0;
      do begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1; t++;
      end while (!acc && t < 2000);
      if (!acc) chk("accept_timeout", 32'(t), 0);
      if (i == 0) wait0 = t - 1;
    end
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 5000) begin @(posedge clk); #1; t++; end
    chk("drain_timeout", 32'(t < 5000), 1);
  endtask

  function automatic logic [15:0] rand_h(input int mode);
    int e;
    case (mode)
      0:       e = $urandom_range(30);
      1:       e = $urandom_range(17, 12);
      default: e = $urandom_range(2);
    endcase
    return {1'($urandom_range(1)), 5'(e), 10'($urandom_range(1023))};
  endfunction

  // Scoreboard and output-stability monitor.
  always @(negedge clk) begin
    if (!resetn) hold_pending = 0;
    else begin
      if (hold_pending) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", {15'd0, out_last, out_data}, {15'd0, hold_last, hold_data});
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("sb_out", {15'd0, out_last, out_data}, {15'd0, exp_q.pop_front()});
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      hold_last    = out_last;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) out_ready = ($urandom_range(99) < 70);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VL-1:0][15:0] t1, t2, va, vz, vr;
    int w;
    t1 = {16'h4200, 16'hBC00, 16'h4000, 16'h3C00};
    t2 = {16'hC400, 16'hB800, 16'hC000, 16'hBC00};
    va = {16'h5000, 16'h3800, 16'hC800, 16'h4400};
    vz = {16'h8000, 16'hBC00, 16'h0000, 16'h8000};
    resetn = 0; in_valid = 0; in_data = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    @(posedge clk); #1; resetn = 1;

    // T1: basic vector and first-output latency
    send_vec(t1, 0, w);
    @(negedge clk);
    chk("lat_no_out_yet", 32'(out_valid), 0);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("lat_first_valid", 32'(out_valid), 1);
    chk("lat_first_data", 32'(out_data), 32'h0000C000);
    wait_idle();

    // T2: all negative
    send_vec(t2, 0, w);
    wait_idle();

    // T3: backpressure on the second output
    send_vec(t1, 0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_data", 32'(out_data), 32'h0000BC00);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1; out_ready = 1;
    wait_idle();
    @(negedge clk);
    chk("bp_reload_ready", 32'(in_ready), 1);

    // T4: reset mid-LOAD, then fresh vector; then reset mid-DRAIN
    @(posedge clk); #1;
    in_valid = 1; in_data = 16'h7000;
    @(posedge clk); #1; in_data = 16'h6000;
    @(posedge clk); #1; in_valid = 0; resetn = 0;
    @(posedge clk); #1; resetn = 1;
    send_vec(t1, 0, w);
    wait_idle();
    out_ready = 0;
    send_vec(t1, 0, w);
    @(posedge clk); #1;
    exp_q.delete();
    resetn = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstd_out_valid", 32'(out_valid), 0);
    chk("rstd_in_ready", 32'(in_ready), 1);
    chk("rstd_busy", 32'(busy), 0);
    @(posedge clk); #1; resetn = 1; out_ready = 1;

    // T5: back-to-back vectors, signed zeros
    send_vec(va, 0, w);
    send_vec(t2, 0, w);
    chk("b2b_stall_cycles", 32'(w), 32'(VL + 1));
    send_vec(vz, 0, w);
    chk("b2b_stall_cycles2", 32'(w), 32'(VL + 1));
    wait_idle();

    // T6: random vectors with random valid/ready
    rdy_rand = 1;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < VL; i++) vr[i] = rand_h(n % 3);
      send_vec(vr, 30, w);
    end
    wait_idle();
    rdy_rand = 0;
    chk("sb_final_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
